// File: rtl/rf_writeback.sv
// Write-back stage: a one-entry pending register in front of a 32-entry register array.
// Two combinational read ports see a pending write through a bypass before it commits.
module rf_writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  wb_zero,
  input  logic                  wb_carry,
  input  logic                  wb_hold,
  input  logic [ADDR_WIDTH-1:0] Rs_addr,
  input  logic [ADDR_WIDTH-1:0] Rt_addr,
  output logic [DATA_WIDTH-1:0] Rs_data,
  output logic [DATA_WIDTH-1:0] Rt_data,
  output logic                  zero_flag,
  output logic                  carry_flag,
  output logic                  pend_valid,
  output logic [CNT_WIDTH-1:0]  commit_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regArray [DEPTH];
  logic                  pendValidR;
  logic [ADDR_WIDTH-1:0] pendAddrR;
  logic [DATA_WIDTH-1:0] pendDataR;
  logic                  zeroR;
  logic                  carryR;
  logic [CNT_WIDTH-1:0]  commitCntR;

  logic acceptS;
  logic commitS;

  // Handshake: a stalled, full pending entry is the only thing that blocks new requests.
  always_comb begin
    in_ready = !pendValidR || !wb_hold;
    acceptS  = in_valid && in_ready;
    commitS  = pendValidR && !wb_hold;
  end

  // Pending entry, last-accepted flags and commit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pendValidR <= 1'b0;
      pendAddrR  <= {ADDR_WIDTH{1'b0}};
      pendDataR  <= {DATA_WIDTH{1'b0}};
      zeroR      <= 1'b0;
      carryR     <= 1'b0;
      commitCntR <= {CNT_WIDTH{1'b0}};
    end else begin
      if (acceptS) begin
        pendValidR <= 1'b1;
        pendAddrR  <= wb_addr;
        pendDataR  <= wb_data;
        zeroR      <= wb_zero;
        carryR     <= wb_carry;
      end else if (commitS) begin
        pendValidR <= 1'b0;
      end
      if (commitS) begin
        commitCntR <= commitCntR + CNT_WIDTH'(1);
      end
    end
  end

  // Register array; entry 0 is hard-wired to zero and never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regArray[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (commitS && (pendAddrR != {ADDR_WIDTH{1'b0}})) begin
      regArray[pendAddrR] <= pendDataR;
    end
  end

  // Read ports: the pending entry is newer than the array, so it wins.
  always_comb begin
    if (Rs_addr == {ADDR_WIDTH{1'b0}}) begin
      Rs_data = {DATA_WIDTH{1'b0}};
    end else if (pendValidR && (pendAddrR == Rs_addr)) begin
      Rs_data = pendDataR;
    end else begin
      Rs_data = regArray[Rs_addr];
    end
    if (Rt_addr == {ADDR_WIDTH{1'b0}}) begin
      Rt_data = {DATA_WIDTH{1'b0}};
    end else if (pendValidR && (pendAddrR == Rt_addr)) begin
      Rt_data = pendDataR;
    end else begin
      Rt_data = regArray[Rt_addr];
    end
  end

  assign zero_flag    = zeroR;
  assign carry_flag   = carryR;
  assign pend_valid   = pendValidR;
  assign commit_count = commitCntR;

endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback: bypass, back-to-back writes, stall, r0, async reset, counter wrap.
module tb_rf_writeback;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_zero;
  logic        wb_carry;
  logic        wb_hold;
  logic [4:0]  Rs_addr;
  logic [4:0]  Rt_addr;
  logic [31:0] Rs_data;
  logic [31:0] Rt_data;
  logic        zero_flag;
  logic        carry_flag;
  logic        pend_valid;
  logic [15:0] commit_count;

  int nCmp = 0;
  int nErr = 0;

  rf_writeback #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .wb_addr(wb_addr), .wb_data(wb_data), .wb_zero(wb_zero), .wb_carry(wb_carry),
    .wb_hold(wb_hold), .Rs_addr(Rs_addr), .Rt_addr(Rt_addr), .Rs_data(Rs_data),
    .Rt_data(Rt_data), .zero_flag(zero_flag), .carry_flag(carry_flag),
    .pend_valid(pend_valid), .commit_count(commit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic z, input logic c);
    in_valid = v; wb_addr = a; wb_data = d; wb_zero = z; wb_carry = c;
  endtask

  initial begin
    rst_n = 1'b0; wb_hold = 1'b0; Rs_addr = 5'd0; Rt_addr = 5'd0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #12 rst_n = 1'b1;
    tick();

    // 1: reset state
    for (int a = 0; a < 32; a++) begin
      Rs_addr = 5'(a); Rt_addr = 5'(31 - a);
      #1;
      check("rst_rs", Rs_data, 32'h0);
      check("rst_rt", Rt_data, 32'h0);
    end
    check("rst_ready", {31'b0, in_ready}, 32'h1);
    check("rst_pend", {31'b0, pend_valid}, 32'h0);
    check("rst_cnt", {16'b0, commit_count}, 32'h0);

    // 2: single write, bypass then array
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    Rs_addr = 5'd5; #1;
    check("t2_bypass", Rs_data, 32'hDEADBEEF);
    check("t2_carry", {31'b0, carry_flag}, 32'h1);
    check("t2_zero", {31'b0, zero_flag}, 32'h0);
    check("t2_pend", {31'b0, pend_valid}, 32'h1);
    check("t2_cnt0", {16'b0, commit_count}, 32'h0);
    tick();
    check("t2_array", Rs_data, 32'hDEADBEEF);
    check("t2_pend_clr", {31'b0, pend_valid}, 32'h0);
    check("t2_cnt1", {16'b0, commit_count}, 32'h1);

    // 3: back-to-back writes to r7
    Rt_addr = 5'd7;
    drive(1'b1, 5'd7, 32'h1, 1'b0, 1'b0);
    tick();
    check("t3_first", Rt_data, 32'h1);
    drive(1'b1, 5'd7, 32'h2, 1'b0, 1'b0);
    tick();
    check("t3_second", Rt_data, 32'h2);
    check("t3_cnt_mid", {16'b0, commit_count}, 32'h2);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    tick();
    check("t3_final", Rt_data, 32'h2);
    check("t3_pend", {31'b0, pend_valid}, 32'h0);
    check("t3_cnt", {16'b0, commit_count}, 32'h3);

    // 4: stall with a full pending entry
    Rs_addr = 5'd3; Rt_addr = 5'd4;
    drive(1'b1, 5'd3, 32'hAAAA0000, 1'b0, 1'b0);
    tick();
    wb_hold = 1'b1;
    drive(1'b1, 5'd4, 32'h55, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t4_ready", {31'b0, in_ready}, 32'h0);
      check("t4_bypass", Rs_data, 32'hAAAA0000);
      check("t4_r4_old", Rt_data, 32'h0);
      check("t4_cnt", {16'b0, commit_count}, 32'h3);
      tick();
    end
    wb_hold = 1'b0; #1;
    check("t4_ready_rel", {31'b0, in_ready}, 32'h1);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    check("t4_r3", Rs_data, 32'hAAAA0000);
    check("t4_r4_byp", Rt_data, 32'h55);
    check("t4_zero", {31'b0, zero_flag}, 32'h1);
    check("t4_cnt_rel", {16'b0, commit_count}, 32'h4);
    tick();
    check("t4_r4", Rt_data, 32'h55);
    check("t4_cnt_end", {16'b0, commit_count}, 32'h5);

    // 5: writes to r0 are counted but dropped
    Rs_addr = 5'd0;
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    check("t5_r0_pend", Rs_data, 32'h0);
    tick();
    check("t5_r0", Rs_data, 32'h0);
    check("t5_cnt", {16'b0, commit_count}, 32'h6);

    // 6: hold with empty entry, then async reset discards it
    Rs_addr = 5'd9; wb_hold = 1'b1;
    drive(1'b1, 5'd9, 32'h1234, 1'b1, 1'b1);
    #1;
    check("t6_ready_empty", {31'b0, in_ready}, 32'h1);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    check("t6_bypass", Rs_data, 32'h1234);
    check("t6_ready_full", {31'b0, in_ready}, 32'h0);
    check("t6_cnt_hold", {16'b0, commit_count}, 32'h6);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_pend", {31'b0, pend_valid}, 32'h0);
    check("t6_rst_rs", Rs_data, 32'h0);
    check("t6_rst_cnt", {16'b0, commit_count}, 32'h0);
    check("t6_rst_carry", {31'b0, carry_flag}, 32'h0);
    check("t6_rst_zero", {31'b0, zero_flag}, 32'h0);
    #2 rst_n = 1'b1; wb_hold = 1'b0;
    tick();
    check("t6_r9_after", Rs_data, 32'h0);
    check("t6_cnt_after", {16'b0, commit_count}, 32'h0);

    // Counter wrap: 65535 commits, then one more
    Rs_addr = 5'd1;
    for (int i = 0; i < 65535; i++) begin
      drive(1'b1, 5'd1, 32'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    tick();
    check("wrap_pre", {16'b0, commit_count}, 32'hFFFF);
    check("wrap_data", Rs_data, 32'h0000FFFE);
    drive(1'b1, 5'd1, 32'h12345678, 1'b0, 1'b0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    tick();
    check("wrap_cnt", {16'b0, commit_count}, 32'h0);
    check("wrap_r1", Rs_data, 32'h12345678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
